// File: rtl/hap_cmp_pkg.sv
// Shared definitions for the compare pipeline: opcode width, the six
// relational opcode encodings and a legality helper used by both the
// compare core and any model that needs to classify opcodes.
package hap_cmp_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_LT  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_GT  = 5'b01100;
  localparam logic [OPC_W-1:0] OP_EQ  = 5'b01101;
  localparam logic [OPC_W-1:0] OP_GTE = 5'b01110;
  localparam logic [OPC_W-1:0] OP_LTE = 5'b01111;
  localparam logic [OPC_W-1:0] OP_NE  = 5'b10000;

  // True when op is one of the six relational opcodes.
  function automatic logic is_cmp_op(input logic [OPC_W-1:0] op);
    logic ok;
    case (op)
      OP_LT, OP_GT, OP_EQ, OP_GTE, OP_LTE, OP_NE: ok = 1'b1;
      default:                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/compare_core.sv
// Purely combinational relational compare of two WIDTH-bit operands.
// Produces the opcode-selected result bit, an illegal-opcode flag and the
// opcode-independent lt/eq/gt ordering. signed_mode selects
// two's-complement ordering.
module compare_core
  import hap_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic             signed_mode,
  output logic             res,
  output logic             illegal,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  logic [WIDTH-1:0] a_biased;
  logic [WIDTH-1:0] b_biased;

  // Ordering flags: flipping the sign bit maps two's-complement order onto
  // unsigned order, so one unsigned comparator serves both modes.
  always_comb begin
    a_biased = {r1[WIDTH-1] ^ signed_mode, r1[WIDTH-2:0]};
    b_biased = {r2[WIDTH-1] ^ signed_mode, r2[WIDTH-2:0]};
    eq       = (r1 == r2);
    lt       = (a_biased < b_biased);
    gt       = !lt && !eq;
  end

  // Opcode decode of the result bit; unknown opcodes yield 0 and flag illegal.
  always_comb begin
    res     = 1'b0;
    illegal = !is_cmp_op(opcode);
    case (opcode)
      OP_LT:   res = lt;
      OP_GT:   res = gt;
      OP_EQ:   res = eq;
      OP_GTE:  res = gt || eq;
      OP_LTE:  res = lt || eq;
      OP_NE:   res = !eq;
      default: res = 1'b0;
    endcase
  end

endmodule

// File: rtl/compare_pipe.sv
// Two-stage valid/ready compare pipeline. S1 captures the request, S2
// captures the evaluated result; all result outputs come straight from S2
// flops and read zero whenever out_valid is low.
// Optional feature: define CMP_SIGNED_EN to honour in_signed (two's-complement
// ordering); otherwise in_signed is ignored and every compare is unsigned.
module compare_pipe
  import hap_cmp_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int RD_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [WIDTH-1:0]    r1,
  input  logic [WIDTH-1:0]    r2,
  input  logic                in_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RD_WIDTH-1:0] rd,
  output logic                illegal,
  output logic [2:0]          flags
);

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [OPC_W-1:0] s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_r1_q,    s1_r1_d;
  logic [WIDTH-1:0] s1_r2_q,    s1_r2_d;
  logic             s1_sgn;

  // Stage 2 state
  logic                s2_valid_q,   s2_valid_d;
  logic [RD_WIDTH-1:0] s2_rd_q,      s2_rd_d;
  logic                s2_illegal_q, s2_illegal_d;
  logic [2:0]          s2_flags_q,   s2_flags_d;

  // Handshake
  logic s2_load;
  logic s1_accept;

  // Core outputs
  logic core_res, core_illegal, core_lt, core_eq, core_gt;

  assign s2_load   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s2_load;
  assign s1_accept = in_valid && in_ready;

`ifdef CMP_SIGNED_EN
  logic s1_sgn_q, s1_sgn_d;

  // Signed-mode request bit travels with its operands through S1.
  always_comb begin
    s1_sgn_d = s1_sgn_q;
    if (s1_accept) s1_sgn_d = in_signed;
  end

  // Signed-mode register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_sgn_q <= 1'b0;
    else        s1_sgn_q <= s1_sgn_d;
  end

  assign s1_sgn = s1_sgn_q;
`else
  // in_signed stays on the port list for interface stability only.
  logic unused_in_signed;
  assign unused_in_signed = in_signed;
  assign s1_sgn           = 1'b0;
`endif

  compare_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .opcode     (s1_op_q),
    .r1         (s1_r1_q),
    .r2         (s1_r2_q),
    .signed_mode(s1_sgn),
    .res        (core_res),
    .illegal    (core_illegal),
    .lt         (core_lt),
    .eq         (core_eq),
    .gt         (core_gt)
  );

  // S1 next state: load on accept, empty when its content moves to S2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_r1_d    = s1_r1_q;
    s1_r2_d    = s1_r2_q;
    if (s1_accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = opcode;
      s1_r1_d    = r1;
      s1_r2_d    = r2;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // S1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_r1_q    <= '0;
      s1_r2_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_r1_q    <= s1_r1_d;
      s1_r2_q    <= s1_r2_d;
    end
  end

  // S2 next state: capture the evaluated result, or clear the payload once
  // consumed so the outputs read zero while no result is present.
  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_rd_d      = s2_rd_q;
    s2_illegal_d = s2_illegal_q;
    s2_flags_d   = s2_flags_q;
    if (s2_load) begin
      s2_valid_d   = 1'b1;
      s2_rd_d      = '0;
      s2_rd_d[0]   = core_res;
      s2_illegal_d = core_illegal;
      s2_flags_d   = {core_gt, core_eq, core_lt};
    end else if (out_ready) begin
      s2_valid_d   = 1'b0;
      s2_rd_d      = '0;
      s2_illegal_d = 1'b0;
      s2_flags_d   = 3'b000;
    end
  end

  // S2 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_rd_q      <= '0;
      s2_illegal_q <= 1'b0;
      s2_flags_q   <= 3'b000;
    end else begin
      s2_valid_q   <= s2_valid_d;
      s2_rd_q      <= s2_rd_d;
      s2_illegal_q <= s2_illegal_d;
      s2_flags_q   <= s2_flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign rd        = s2_rd_q;
  assign illegal   = s2_illegal_q;
  assign flags     = s2_flags_q;

endmodule

// File: tb/tb_compare_pipe.sv
// Self-checking bench for compare_pipe (WIDTH=8, RD_WIDTH=3). A queue-based
// reference model predicts every result from the relational rules; a
// negedge compare process checks the DUT against it, and directed scenarios
// pin the model with literal expected values. Honours CMP_SIGNED_EN.
module tb_compare_pipe;
  import hap_cmp_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] opcode = '0;
  logic [7:0] r1 = '0;
  logic [7:0] r2 = '0;
  logic       in_signed = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] rd;
  logic       illegal;
  logic [2:0] flags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Packed result: {rd[2:0], illegal, flags[2:0]}
  logic [6:0] model_q[$];
  logic [6:0] log_q[$];
  int         log_cyc[$];

  compare_pipe #(.WIDTH(8), .RD_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .r1(r1), .r2(r2), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .rd(rd),
    .illegal(illegal), .flags(flags)
  );

  always #5 clk = ~clk;

  // Reference: order the operands as integers and apply the opcode meaning.
  function automatic logic [6:0] model(input logic [4:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic sgn);
    int ia, ib;
    logic l, e, g, r;
    ia = sgn ? int'($signed(a)) : int'(a);
    ib = sgn ? int'($signed(b)) : int'(b);
    l = ia < ib;  e = ia == ib;  g = ia > ib;
    r = 1'b0;
    if (op == OP_LT)  r = l;
    if (op == OP_GT)  r = g;
    if (op == OP_EQ)  r = e;
    if (op == OP_GTE) r = g || e;
    if (op == OP_LTE) r = l || e;
    if (op == OP_NE)  r = !e;
    return {2'b00, r, !is_cmp_op(op), g, e, l};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard bookkeeping at the active edge (pre-update values).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      cyc++;
      if (out_valid && out_ready) begin
        if (model_q.size() > 0) void'(model_q.pop_front());
        log_q.push_back({rd, illegal, flags});
        log_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
`ifdef CMP_SIGNED_EN
        model_q.push_back(model(opcode, r1, r2, in_signed));
`else
        model_q.push_back(model(opcode, r1, r2, 1'b0));
`endif
      end
    end
  end

  // Per-cycle output comparison on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (model_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else                     chk("out_vs_model", {25'd0, rd, illegal, flags}, {25'd0, model_q[0]});
      end else begin
        chk("idle_zero", {25'd0, rd, illegal, flags}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted; in_valid stays high.
  task automatic send(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, input logic s);
    logic acc;
    opcode = op; r1 = a; r2 = b; in_signed = s; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (model_q.size() == 0 && !out_valid) return;
      step();
    end
    chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  task automatic chk_log(input string name, input int idx, input logic [6:0] exp);
    if (idx >= log_q.size()) chk(name, 32'hDEAD, {25'd0, exp});
    else                     chk(name, {25'd0, log_q[idx]}, {25'd0, exp});
  endtask

  logic [6:0] stream_exp[6];
  logic [6:0] held;

  initial begin
    // Reset held with a request pending.
    in_valid = 1'b1; opcode = OP_EQ; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rd", {29'd0, rd}, 32'd0);
    chk("rst_flags", {29'd0, flags}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Latency: accepted at edge N, out_valid after edge N+1.
    opcode = OP_LT; r1 = 8'd1; r2 = 8'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_n", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_n1", {31'd0, out_valid}, 32'd1);
    drain();

    // Unsigned stream, one result per cycle.
    clear_log();
    send(OP_LT, 8'd3, 8'd5, 1'b0);
    send(OP_GT, 8'd200, 8'd7, 1'b0);
    send(OP_EQ, 8'd9, 8'd9, 1'b0);
    send(OP_GTE, 8'd4, 8'd4, 1'b0);
    send(OP_LTE, 8'd6, 8'd5, 1'b0);
    send(OP_NE, 8'd1, 8'd1, 1'b0);
    drain();
    stream_exp[0] = 7'b001_0_001; stream_exp[1] = 7'b001_0_100;
    stream_exp[2] = 7'b001_0_010; stream_exp[3] = 7'b001_0_010;
    stream_exp[4] = 7'b000_0_100; stream_exp[5] = 7'b000_0_010;
    for (int i = 0; i < 6; i++) chk_log("stream", i, stream_exp[i]);
    if (log_cyc.size() == 6) chk("stream_rate", log_cyc[5] - log_cyc[0], 32'd5);
    else                     chk("stream_count", log_cyc.size(), 32'd6);

    // Illegal opcode then a legal one.
    clear_log();
    send(5'b00000, 8'd0, 8'd0, 1'b0);
    send(OP_EQ, 8'd2, 8'd3, 1'b0);
    drain();
    chk_log("illegal_op", 0, 7'b000_1_010);
    chk_log("legal_after", 1, 7'b000_0_001);

    // Backpressure: out_ready low, three requests.
    clear_log();
    out_ready = 1'b0;
    opcode = OP_LT; r1 = 8'd1; r2 = 8'd2; in_valid = 1'b1;
    step();                                  // op0 accepted
    opcode = OP_GT; r1 = 8'd1; r2 = 8'd2;
    step();                                  // op1 accepted
    opcode = OP_EQ; r1 = 8'd7; r2 = 8'd7;
    held = {rd, illegal, flags};
    chk("bp_first_held", {25'd0, held}, {25'd0, 7'b001_0_001});
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    step();
    chk("bp_rd_stable", {25'd0, rd, illegal, flags}, {25'd0, held});
    step();
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    chk("bp_rd_stable2", {25'd0, rd, illegal, flags}, {25'd0, held});
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();                                  // op2 accepted
    drain();
    chk_log("bp_order0", 0, 7'b001_0_001);
    chk_log("bp_order1", 1, 7'b000_0_001);
    chk_log("bp_order2", 2, 7'b001_0_010);
    chk("bp_count", log_q.size(), 32'd3);

    // Signed versus unsigned LT(FF,01).
    clear_log();
    send(OP_LT, 8'hFF, 8'h01, 1'b1);
    send(OP_LT, 8'hFF, 8'h01, 1'b0);
    drain();
`ifdef CMP_SIGNED_EN
    chk_log("signed_lt", 0, 7'b001_0_001);
`else
    chk_log("signed_lt_ignored", 0, 7'b000_0_100);
`endif
    chk_log("unsigned_lt", 1, 7'b000_0_100);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(OP_NE, 8'd4, 8'd5, 1'b0);
    send(OP_GTE, 8'd9, 8'd5, 1'b0);
    in_valid = 1'b0;
    step();
    chk("full_before_rst", {30'd0, out_valid, in_ready}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_payload", {25'd0, rd, illegal, flags}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    clear_log();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end
    chk("no_stale_log", log_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
